// File: rtl/fwd_hazard_tracker_pkg.sv
// Shared types for the forwarding / load-use hazard tracker.
// Slot destination width is fixed at SLOT_AW; narrower register addresses are
// zero-extended on entry, which preserves equality compares.
package fwd_pkg;

  localparam int SLOT_AW = 8;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] dst;
    logic               rw;
    logic               ld;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  // A slot matches a source when it will really write that (non-zero) register.
  function automatic logic slot_hits(input slot_t s, input logic [SLOT_AW-1:0] src);
    return s.valid && s.rw && (s.dst != '0) && (s.dst == src);
  endfunction

endpackage

// File: rtl/fwd_hazard_tracker_if.sv
// ID-stage <-> hazard tracker bundle. master = pipeline control, slave = tracker.
interface fwd_hazard_tracker_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) ();

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_use;
  logic [REG_AW-1:0]         id_dst_addr;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      flush;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_src_addr, id_src_use, id_dst_addr,
           id_reg_write, id_mem_read, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_use, id_dst_addr,
           id_reg_write, id_mem_read, flush,
    output fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/fwd_slot_reg.sv
// One in-flight instruction slot with synchronous active-low clear and a
// bubble-insert input that loads an invalid slot instead of d.
module fwd_slot_reg
  import fwd_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_n,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  // Slot register: clear or bubble forces an empty slot, otherwise advance.
  always_ff @(posedge clk_i) begin
    if (!rst_n || bubble) begin
      q <= BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding select and load-use stall unit for the 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destinations, registers per-source forwarding selects so
// they are valid in EX, raises a one-cycle stall on load-use, counts stalls.
// Optional macro FWD_WB_BYPASS_EN enables select 2'b11 from the wb slot.
module fwd_hazard_tracker
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  fwd_hazard_tracker_if.slave  bus
);

  slot_t                ex_slot_p0;
  slot_t                mem_slot_p1;
  slot_t                wb_slot_p2;
  slot_t                id_slot;
  logic                 issue;
  logic                 stall;
  logic [NUM_SRC-1:0]   ld_hit;
  logic [2*NUM_SRC-1:0] fwd_nxt;
  logic [2*NUM_SRC-1:0] fwd_sel_p0;
  logic [CNT_W-1:0]     stall_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign id_slot = '{valid: 1'b1,
                     dst:   SLOT_AW'(bus.id_dst_addr),
                     rw:    bus.id_reg_write,
                     ld:    bus.id_mem_read};

  assign stall = bus.id_valid && (|ld_hit);
  assign issue = bus.id_valid && !bus.flush && !stall;

  // ---- ID -> EX boundary ----
  fwd_slot_reg u_ex  (.clk_i(clk_i), .rst_n(rst_n), .bubble(!issue), .d(id_slot),     .q(ex_slot_p0));
  // ---- EX -> MEM boundary ----
  fwd_slot_reg u_mem (.clk_i(clk_i), .rst_n(rst_n), .bubble(1'b0),   .d(ex_slot_p0),  .q(mem_slot_p1));
  // ---- MEM -> WB boundary ----
  fwd_slot_reg u_wb  (.clk_i(clk_i), .rst_n(rst_n), .bubble(1'b0),   .d(mem_slot_p1), .q(wb_slot_p2));

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [SLOT_AW-1:0] src;
    logic               used;
    logic [1:0]         sel;

    assign src  = SLOT_AW'(bus.id_src_addr[k*REG_AW +: REG_AW]);
    assign used = bus.id_src_use[k] && (src != '0);

    // Per-source priority: youngest producer wins, independent of other sources.
    always_comb begin
      sel = FWD_NONE;
      if (used) begin
        if (slot_hits(ex_slot_p0, src)) begin
          sel = FWD_EXMEM;
        end else if (slot_hits(mem_slot_p1, src)) begin
          sel = FWD_MEMWB;
        end
`ifdef FWD_WB_BYPASS_EN
        else if (slot_hits(wb_slot_p2, src)) begin
          sel = FWD_WB;
        end
`endif
      end
    end

    assign fwd_nxt[2*k +: 2] = sel;
    assign ld_hit[k]         = used && ex_slot_p0.ld && slot_hits(ex_slot_p0, src);
  end

`ifndef FWD_WB_BYPASS_EN
  // Without the bypass the wb slot is tracked but never compared.
  logic unused_wb;
  assign unused_wb = ^wb_slot_p2;
`endif

  // ---- ID -> EX boundary: forwarding select, cleared on any bubble edge ----
  always_ff @(posedge clk_i) begin
    if (!rst_n || !issue) begin
      fwd_sel_p0 <= '0;
    end else begin
      fwd_sel_p0 <= fwd_nxt;
    end
  end

  // Stall cycle counter, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign bus.fwd_sel   = fwd_sel_p0;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
